test_status_monitor: RTL and testbench

Synthesizable, parametrised end-of-test controller for harness top levels. It sequences DUT reset release and counts run cycles. It aggregates pass/fail from N independent test channels, enforces a cycle timeout and a heartbeat watchdog, and gates a waveform-dump window. It sits between the clock/reset source and the TestHarness, and drives a single registered verdict that a simulation wrapper or an FPGA status register can sample.

---
 rtl/test_status_monitor.sv | 184 ++++++++++++++++++
 tb/tb_test_status_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/test_status_monitor.sv
`timescale 1ns/1ps
// End-of-test controller: sequences DUT reset, counts run cycles, aggregates
// channel pass/fail, enforces timeout and heartbeat watchdog, gates dump window.
module test_status_monitor #(
  parameter int unsigned N_CHANNELS   = 4,
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned HB_TIMEOUT   = 0,
  localparam int unsigned CH_W        = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] io_chan_en,
  input  logic                  io_require_all,
  input  logic [N_CHANNELS-1:0] io_success,
  input  logic [N_CHANNELS-1:0] io_failure,
  input  logic                  io_heartbeat,
  input  logic [CNT_W-1:0]      io_max_cycles,
  input  logic [CNT_W-1:0]      io_dump_start,
  input  logic [CNT_W-1:0]      io_dump_len,
  output logic                  dut_reset,
  output logic                  io_dump_en,
  output logic                  io_done,
  output logic                  io_pass,
  output logic [2:0]            io_fail_code,
  output logic [CH_W-1:0]       io_fail_chan,
  output logic [CNT_W-1:0]      io_cycle_count
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned HB_W   = (HB_TIMEOUT > 0) ? $clog2(HB_TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_CHAN    = 3'd1;
  localparam logic [2:0] CODE_TIMEOUT = 3'd2;
  localparam logic [2:0] CODE_HB      = 3'd3;
  localparam logic [2:0] CODE_CFG     = 3'd4;

  logic [1:0]            state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [HB_W-1:0]       hb_q, hb_d;
  logic [N_CHANNELS-1:0] sticky_q, sticky_d;
  logic                  dut_reset_q, dut_reset_d;
  logic                  dump_en_q, dump_en_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [2:0]            code_q, code_d;
  logic [CH_W-1:0]       chan_q, chan_d;

  logic [N_CHANNELS-1:0] fail_vec;
  logic [N_CHANNELS-1:0] sticky_ok;
  logic [CH_W-1:0]       fail_idx;
  logic [HB_W-1:0]       hb_eff;
  logic                  hb_sat;
  logic                  hb_trip;
  logic                  success_hit;
  logic [CNT_W:0]        win_cnt, win_start, win_end;
  logic                  in_win;

  // Channel evaluation and heartbeat watchdog terms for the current cycle
  always_comb begin
    fail_vec  = io_failure & io_chan_en;
    sticky_ok = sticky_q | (io_success & io_chan_en);
    fail_idx  = '0;
    for (int i = int'(N_CHANNELS) - 1; i >= 0; i--) begin
      if (fail_vec[i]) fail_idx = CH_W'(i);
    end
    success_hit = io_require_all ? (&(sticky_ok | ~io_chan_en)) : (|sticky_ok);
    // A heartbeat this cycle counts as zero elapsed, cancelling a pending trip
    hb_eff  = io_heartbeat ? '0 : hb_q;
    hb_sat  = (hb_eff == HB_W'(HB_TIMEOUT));
    hb_trip = (HB_TIMEOUT != 0) && hb_sat;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hb_d        = hb_q;
    sticky_d    = sticky_q;
    dut_reset_d = dut_reset_q;
    done_d      = done_q;
    pass_d      = pass_q;
    code_d      = code_q;
    chan_d      = chan_q;
    case (state_q)
      ST_HOLD: begin
        dut_reset_d = 1'b1;
        sticky_d    = '0;
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d     = ST_RUN;
          dut_reset_d = 1'b0;
          hold_d      = '0;
          cnt_d       = '0;
          hb_d        = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        sticky_d = sticky_ok;
        if (io_chan_en == '0) begin
          state_d = ST_FAIL;
          done_d  = 1'b1;
          code_d  = CODE_CFG;
        end else if (fail_vec != '0) begin
          state_d = ST_FAIL;
          done_d  = 1'b1;
          code_d  = CODE_CHAN;
          chan_d  = fail_idx;
        end else if ((io_max_cycles != '0) && (cnt_q >= io_max_cycles)) begin
          state_d = ST_FAIL;
          done_d  = 1'b1;
          code_d  = CODE_TIMEOUT;
        end else if (hb_trip) begin
          state_d = ST_FAIL;
          done_d  = 1'b1;
          code_d  = CODE_HB;
        end else if (success_hit) begin
          state_d = ST_PASS;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          hb_d  = hb_sat ? hb_eff : hb_eff + HB_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Dump window evaluated on the next count so the flop lines up with it
  always_comb begin
    win_cnt   = {1'b0, cnt_d};
    win_start = {1'b0, io_dump_start};
    win_end   = win_start + {1'b0, io_dump_len};
    in_win    = (win_cnt >= win_start) && ((io_dump_len == '0) || (win_cnt < win_end));
    dump_en_d = (state_d == ST_RUN) && in_win;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      cnt_q       <= '0;
      hb_q        <= '0;
      sticky_q    <= '0;
      dut_reset_q <= 1'b1;
      dump_en_q   <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      code_q      <= CODE_NONE;
      chan_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      hb_q        <= hb_d;
      sticky_q    <= sticky_d;
      dut_reset_q <= dut_reset_d;
      dump_en_q   <= dump_en_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      code_q      <= code_d;
      chan_q      <= chan_d;
    end
  end

  assign dut_reset      = dut_reset_q;
  assign io_dump_en     = dump_en_q;
  assign io_done        = done_q;
  assign io_pass        = pass_q;
  assign io_fail_code   = code_q;
  assign io_fail_chan   = chan_q;
  assign io_cycle_count = cnt_q;

endmodule

// File: tb/tb_test_status_monitor.sv
`timescale 1ns/1ps
// Bench for test_status_monitor: directed scenarios plus randomized traffic
// checked every cycle against an event-level model of the controller.
module tb_test_status_monitor;

  localparam int RC = 16;
  localparam int HB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  chan_en, success, failure;
  logic        require_all, heartbeat;
  logic [63:0] max_cycles, dump_start, dump_len;
  logic        dut_reset, dump_en, done, pass;
  logic [2:0]  fail_code;
  logic [1:0]  fail_chan;
  logic [63:0] cycle_count;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 = holding DUT in reset, 1 = running, 2 = verdict reached
  int          m_phase;
  int          m_hold;
  logic [63:0] m_k;
  logic [63:0] m_last_hb;
  logic [3:0]  m_succ;
  logic        m_pass;
  logic [2:0]  m_code;
  logic [1:0]  m_chan;

  test_status_monitor #(
    .N_CHANNELS(4), .CNT_W(64), .RESET_CYCLES(RC), .HB_TIMEOUT(HB)
  ) dut (
    .clock(clk), .reset(reset), .io_chan_en(chan_en), .io_require_all(require_all),
    .io_success(success), .io_failure(failure), .io_heartbeat(heartbeat),
    .io_max_cycles(max_cycles), .io_dump_start(dump_start), .io_dump_len(dump_len),
    .dut_reset(dut_reset), .io_dump_en(dump_en), .io_done(done), .io_pass(pass),
    .io_fail_code(fail_code), .io_fail_chan(fail_chan), .io_cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic in_window(input logic [63:0] k, input logic [63:0] s,
                                     input logic [63:0] l);
    logic [64:0] e;
    e = {1'b0, s} + {1'b0, l};
    return (k >= s) && ((l == 64'd0) || ({1'b0, k} < e));
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_update();
    logic [3:0] f, sok;
    logic       ok;
    if (reset) begin
      m_phase = 0; m_hold = 0; m_k = 0; m_last_hb = 0; m_succ = 0;
      m_pass = 0; m_code = 0; m_chan = 0;
    end else if (m_phase == 0) begin
      if (m_hold == RC - 1) begin
        m_phase = 1; m_k = 0; m_last_hb = 0; m_succ = 0;
      end else begin
        m_hold++;
      end
    end else if (m_phase == 1) begin
      f   = failure & chan_en;
      sok = m_succ | (success & chan_en);
      ok  = require_all ? ((sok | ~chan_en) == 4'hF) : (sok != 4'h0);
      m_succ = sok;
      if (chan_en == 4'h0) begin
        m_phase = 2; m_code = 3'd4;
      end else if (f != 4'h0) begin
        m_phase = 2; m_code = 3'd1;
        for (int i = 3; i >= 0; i--) if (f[i]) m_chan = 2'(i);
      end else if (max_cycles != 0 && m_k >= max_cycles) begin
        m_phase = 2; m_code = 3'd2;
      end else if (!heartbeat && (m_k - m_last_hb) >= 64'(HB)) begin
        m_phase = 2; m_code = 3'd3;
      end else if (ok) begin
        m_phase = 2; m_pass = 1;
      end else begin
        if (heartbeat) m_last_hb = m_k;
        if (m_k != '1) m_k = m_k + 1;
      end
    end
  endtask

  task automatic check_outputs();
    cmp("dut_reset", 64'(dut_reset), 64'(m_phase == 0));
    cmp("done", 64'(done), 64'(m_phase == 2));
    cmp("pass", 64'(pass), 64'(m_pass));
    cmp("fail_code", 64'(fail_code), 64'(m_code));
    cmp("fail_chan", 64'(fail_chan), 64'(m_chan));
    cmp("cycle_count", cycle_count, m_k);
    cmp("dump_en", 64'(dump_en),
        64'(m_phase == 1 && in_window(m_k, dump_start, dump_len)));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Reset, then confirm the hold length; returns observing run cycle 0
  task automatic hold_check();
    int n;
    reset = 1'b1;
    step();
    cmp("rst_dut_reset", 64'(dut_reset), 64'd1);
    cmp("rst_done", 64'(done), 64'd0);
    cmp("rst_count", cycle_count, 64'd0);
    cmp("rst_code", 64'(fail_code), 64'd0);
    cmp("rst_dump", 64'(dump_en), 64'd0);
    reset = 1'b0;
    n = 0;
    while (dut_reset === 1'b1 && n < 100) begin
      n++;
      step();
    end
    cmp("hold_len", 64'(n), 64'd16);
    cmp("run0_count", cycle_count, 64'd0);
  endtask

  initial begin
    int n_hi, first_hi, last_hi, term_cnt, base_en, hb_mode;
    reset = 1'b1; chan_en = 4'hF; success = 0; failure = 0; require_all = 0;
    heartbeat = 1; max_cycles = 0; dump_start = '1; dump_len = 0;
    step();

    // All-mode pass with ch2 disabled
    require_all = 1; chan_en = 4'b1011;
    hold_check();
    for (int r = 0; r < 30 && m_phase != 2; r++) begin
      success = (r == 5) ? 4'b0001 : (r == 9) ? 4'b0010 : (r == 12) ? 4'b1000 : 4'b0000;
      step();
    end
    success = 0;
    cmp("allpass_done", 64'(done), 64'd1);
    cmp("allpass_pass", 64'(pass), 64'd1);
    cmp("allpass_code", 64'(fail_code), 64'd0);
    cmp("allpass_count", cycle_count, 64'd12);

    // Failure beats success in the same cycle
    require_all = 0; chan_en = 4'hF;
    hold_check();
    for (int r = 0; r < 30 && m_phase != 2; r++) begin
      success = (r == 7) ? 4'b0100 : 4'b0000;
      failure = (r == 7) ? 4'b0010 : 4'b0000;
      step();
    end
    success = 0; failure = 0;
    cmp("chanfail_code", 64'(fail_code), 64'd1);
    cmp("chanfail_chan", 64'(fail_chan), 64'd1);
    cmp("chanfail_pass", 64'(pass), 64'd0);
    cmp("chanfail_count", cycle_count, 64'd7);

    // Cycle timeout, then no timeout for a long run
    max_cycles = 100;
    hold_check();
    for (int r = 0; r < 200 && m_phase != 2; r++) step();
    cmp("timeout_code", 64'(fail_code), 64'd2);
    cmp("timeout_count", cycle_count, 64'd100);
    max_cycles = 0;
    hold_check();
    repeat (10000) step();
    cmp("notimeout_done", 64'(done), 64'd0);
    cmp("notimeout_count", cycle_count, 64'd10000);

    // Heartbeat stops after run 40
    hold_check();
    for (int r = 0; r < 100 && m_phase != 2; r++) begin
      heartbeat = (r % 8 == 0) && (r <= 40);
      step();
    end
    heartbeat = 1;
    cmp("hb_code", 64'(fail_code), 64'd3);
    cmp("hb_count", cycle_count, 64'd48);

    // Empty enable mask
    hold_check();
    chan_en = 4'h0;
    step();
    chan_en = 4'hF;
    cmp("cfg_done", 64'(done), 64'd1);
    cmp("cfg_code", 64'(fail_code), 64'd4);
    cmp("cfg_count", cycle_count, 64'd0);

    // Dump window 10..14, then reset mid-run at run 20
    dump_start = 10; dump_len = 5;
    hold_check();
    n_hi = 0; first_hi = -1; last_hi = -1;
    for (int r = 0; r <= 20; r++) begin
      if (dump_en === 1'b1) begin
        n_hi++;
        if (first_hi < 0) first_hi = int'(cycle_count);
        last_hi = int'(cycle_count);
      end
      if (r < 20) step();
    end
    cmp("dump_len_obs", 64'(n_hi), 64'd5);
    cmp("dump_first", 64'(first_hi), 64'd10);
    cmp("dump_last", 64'(last_hi), 64'd14);
    hold_check();

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      require_all = 1'($urandom_range(0, 1));
      dump_start  = 64'($urandom_range(0, 30));
      dump_len    = 64'($urandom_range(0, 8));
      max_cycles  = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(10, 60));
      base_en     = $urandom_range(1, 15);
      hb_mode     = $urandom_range(0, 2);
      hold_check();
      term_cnt = 0;
      for (int c = 0; c < 90; c++) begin
        chan_en   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(base_en);
        success   = 4'($urandom & $urandom & $urandom);
        failure   = ($urandom_range(0, 40) == 0) ? 4'($urandom) : 4'h0;
        heartbeat = (hb_mode == 0) ? 1'b1 : ($urandom_range(0, hb_mode * 4) == 0);
        reset     = ($urandom_range(0, 150) == 0);
        step();
        reset = 1'b0;
        if (m_phase == 2) begin
          term_cnt++;
          if (term_cnt > 3) break;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
